// File: rtl/keycode_onehot_driver.sv
// Keypad emulator: turns 4-bit key codes into timed one-hot key-line pulses (hold, then gap).
// Optional macro KEY_QUEUE_EN inserts a 4-entry code FIFO in front of the press/gap sequencer.
module keycode_onehot_driver #(
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 8,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        code_valid,
   input  logic [3:0]  code,
   output logic        code_ready,
   output logic [15:0] d,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRESS = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             take;
   logic [3:0]       take_code;

   // Inverse of the 16-key encoder: code 0 is the top line, code c drives line c-1.
   function automatic logic [15:0] decode(input logic [3:0] c);
      logic [15:0] one;
      one = 16'h0001;
      if (c == 4'h0)
         decode = 16'h8000;
      else
         decode = one << (c - 4'h1);
   endfunction

`ifdef KEY_QUEUE_EN
   logic [3:0] fifo_mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] fill;
   logic       fifo_full;
   logic       fifo_empty;
   logic       push;

   assign fifo_full  = (fill == 3'd4);
   assign fifo_empty = (fill == 3'd0);
   assign code_ready = !fifo_full;
   assign push       = code_valid && code_ready;
   assign take       = (state == ST_IDLE) && !fifo_empty;
   assign take_code  = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= code;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 2'd1;
         if (take)
            rd_ptr <= rd_ptr + 2'd1;
         case ({push, take})
            2'b10:   fill <= fill + 3'd1;
            2'b01:   fill <= fill - 3'd1;
            default: fill <= fill;
         endcase
      end
   end
`else
   assign code_ready = (state == ST_IDLE);
   assign take       = code_valid && code_ready;
   assign take_code  = code;
`endif

   // Sequencer: d is registered, so it follows the accepting edge by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         d     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (take) begin
                  d     <= decode(take_code);
                  cnt   <= HOLD_LAST;
                  state <= ST_PRESS;
               end
            end
            ST_PRESS: begin
               if (cnt == CNT_ZERO) begin
                  d <= '0;
                  if (GAP_CYCLES > 0) begin
                     cnt   <= GAP_LAST;
                     state <= ST_GAP;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            ST_GAP: begin
               if (cnt == CNT_ZERO)
                  state <= ST_IDLE;
               else
                  cnt <= cnt - CNT_ONE;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               d     <= '0;
            end
         endcase
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (cnt == CNT_ZERO) &&
                 (((state == ST_PRESS) && (GAP_CYCLES == 0)) || (state == ST_GAP));

endmodule

// File: tb/tb_keycode_onehot_driver.sv
// Bench for keycode_onehot_driver (base build): a default instance (hold 16, gap 8) and a
// minimal instance (hold 1, gap 0), both checked against a cycles-since-accept reference model.
module tb_keycode_onehot_driver;

   localparam int H0 = 16;
   localparam int G0 = 8;
   localparam int H1 = 1;
   localparam int G1 = 0;

   logic        clk;
   logic        rst_n;
   logic        v0, v1;
   logic [3:0]  c0, c1;
   logic        r0, r1;
   logic [15:0] d0, d1;
   logic        b0, b1;
   logic        dn0, dn1;

   int n_checks;
   int n_fail;

   // Model: t = cycles since the accepting edge (0 = idle), key = accepted code.
   int         t0, t1;
   logic [3:0] key0, key1;

   keycode_onehot_driver #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .code_valid(v0), .code(c0),
      .code_ready(r0), .d(d0), .busy(b0), .done(dn0));

   keycode_onehot_driver #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1), .CNT_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .code_valid(v1), .code(c1),
      .code_ready(r1), .d(d1), .busy(b1), .done(dn1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] onehot(input logic [3:0] k);
      int idx;
      idx = (k == 4'h0) ? 15 : (int'(k) - 1);
      onehot = 16'(2 ** idx);
   endfunction

   // Expected {d, busy, done, code_ready} from the position inside a key sequence.
   function automatic logic [18:0] expv(input int t, input logic [3:0] k, input int h, input int g);
      logic [15:0] ed;
      ed = (t >= 1 && t <= h) ? onehot(k) : 16'h0000;
      expv = {ed, (t != 0), (t != 0 && t == h + g), (t == 0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         if (t0 == 0) begin
            if (v0) begin t0 = 1; key0 = c0; end
         end else if (t0 == H0 + G0) t0 = 0;
         else t0++;
         if (t1 == 0) begin
            if (v1) begin t1 = 1; key1 = c1; end
         end else if (t1 == H1 + G1) t1 = 0;
         else t1++;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; c0 = '0; c1 = '0; t0 = 0; t1 = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if ({d0, b0, dn0, r0} !== 19'h00001) begin
         n_fail++; $display("FAIL reset_u0 got %h exp %h", {d0, b0, dn0, r0}, 19'h00001);
      end
      n_checks++;
      if ({d1, b1, dn1, r1} !== 19'h00001) begin
         n_fail++; $display("FAIL reset_u1 got %h exp %h", {d1, b1, dn1, r1}, 19'h00001);
      end
   endtask

   task automatic test_code0();
      int nz, ndone;
      nz = 0; ndone = 0;
      c0 = 4'h0; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      for (int i = 0; i <= H0 + G0; i++) begin
         n_checks++;
         if ({d0, b0, dn0, r0} !== expv(t0, key0, H0, G0)) begin
            n_fail++; $display("FAIL code0 t=%0d got %h exp %h", t0, {d0, b0, dn0, r0}, expv(t0, key0, H0, G0));
         end
         if (d0 == 16'h8000) nz++;
         if (dn0) ndone++;
         tick();
      end
      n_checks++;
      if (nz !== H0 || ndone !== 1) begin
         n_fail++; $display("FAIL code0_counts got hold=%0d done=%0d exp hold=%0d done=1", nz, ndone, H0);
      end
   endtask

   task automatic test_sweep();
      int nz;
      for (int k = 1; k < 16; k++) begin
         nz = 0;
         c0 = 4'(k); v0 = 1'b1;
         tick();
         v0 = 1'b0;
         for (int i = 0; i <= H0 + G0; i++) begin
            n_checks++;
            if ({d0, b0, dn0, r0} !== expv(t0, key0, H0, G0)) begin
               n_fail++; $display("FAIL sweep k=%0d t=%0d got %h exp %h", k, t0, {d0, b0, dn0, r0}, expv(t0, key0, H0, G0));
            end
            if (d0 != 16'h0000) nz++;
            tick();
         end
         n_checks++;
         if (nz !== H0) begin
            n_fail++; $display("FAIL sweep_hold k=%0d got %0d exp %0d", k, nz, H0);
         end
      end
   endtask

   task automatic test_short();
      c1 = 4'h5; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      n_checks++;
      if ({d1, b1, dn1, r1} !== {16'h0010, 1'b1, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL short_press got %h exp %h", {d1, b1, dn1, r1}, {16'h0010, 3'b110});
      end
      tick();
      n_checks++;
      if ({d1, b1, dn1, r1} !== 19'h00001) begin
         n_fail++; $display("FAIL short_idle got %h exp %h", {d1, b1, dn1, r1}, 19'h00001);
      end
   endtask

   task automatic test_hold_valid();
      c0 = 4'h3; v0 = 1'b1;
      tick();
      c0 = 4'h9;
      for (int i = 0; i <= H0 + G0 + 1; i++) begin
         n_checks++;
         if ({d0, b0, dn0, r0} !== expv(t0, key0, H0, G0)) begin
            n_fail++; $display("FAIL hold_valid t=%0d got %h exp %h", t0, {d0, b0, dn0, r0}, expv(t0, key0, H0, G0));
         end
         tick();
      end
      v0 = 1'b0;
      n_checks++;
      if (d0 !== 16'h0100) begin
         n_fail++; $display("FAIL hold_valid_second got %h exp %h", d0, 16'h0100);
      end
      for (int i = 0; i < H0 + G0; i++) begin
         n_checks++;
         if ({d0, b0, dn0, r0} !== expv(t0, key0, H0, G0)) begin
            n_fail++; $display("FAIL hold_valid2 t=%0d got %h exp %h", t0, {d0, b0, dn0, r0}, expv(t0, key0, H0, G0));
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         v0 = ($urandom_range(0, 2) == 0);
         c0 = 4'($urandom);
         v1 = ($urandom_range(0, 1) == 0);
         c1 = 4'($urandom);
         tick();
         n_checks++;
         if ({d0, b0, dn0, r0} !== expv(t0, key0, H0, G0)) begin
            n_fail++; $display("FAIL random_u0 i=%0d got %h exp %h", i, {d0, b0, dn0, r0}, expv(t0, key0, H0, G0));
         end
         n_checks++;
         if ({d1, b1, dn1, r1} !== expv(t1, key1, H1, G1)) begin
            n_fail++; $display("FAIL random_u1 i=%0d got %h exp %h", i, {d1, b1, dn1, r1}, expv(t1, key1, H1, G1));
         end
      end
      v0 = 1'b0; v1 = 1'b0;
      for (int i = 0; i < H0 + G0 + 1; i++) tick();
   endtask

   task automatic test_async_reset();
      c0 = 4'hA; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (d0 !== 16'h0200) begin
         n_fail++; $display("FAIL async_pre got %h exp %h", d0, 16'h0200);
      end
      #2 rst_n = 1'b0;
      t0 = 0; t1 = 0;
      #1;
      n_checks++;
      if ({d0, b0, dn0} !== 18'h0) begin
         n_fail++; $display("FAIL async_reset got %h exp %h", {d0, b0, dn0}, 18'h0);
      end
      #2 rst_n = 1'b1;
      tick();
      n_checks++;
      if ({d0, b0, dn0, r0} !== 19'h00001) begin
         n_fail++; $display("FAIL async_after got %h exp %h", {d0, b0, dn0, r0}, 19'h00001);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0; n_fail = 0;
      key0 = '0; key1 = '0;
      test_reset();
      test_code0();
      test_sweep();
      test_short();
      test_hold_valid();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
